branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/bru_pkg.sv | 41 ++++
 rtl/branch_cond_eval.sv | 42 ++++
 rtl/branch_resolve_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - shared encodings and helpers for the branch resolve unit
//
// Holds the cmp_op encoding, the FSM state encoding and a helper that
// tells whether every operand a given comparison needs is available.
package bru_pkg;

  localparam int OFFSET_W = 16;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_BGEZ = 3'd1,
    OP_BEQ  = 3'd2,
    OP_BNE  = 3'd3,
    OP_BGTZ = 3'd4,
    OP_BLEZ = 3'd5,
    OP_BLTZ = 3'd6,
    OP_RSVD = 3'd7
  } cmp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_OPS = 2'd1,
    ST_RESULT   = 2'd2
  } bru_state_e;

  // NONE and the reserved op need no operands, so they resolve immediately.
  function automatic logic ops_ready(input logic [2:0] op, input logic a_ok, input logic b_ok);
    logic rdy;
    case (cmp_op_e'(op))
      OP_BEQ, OP_BNE:                    rdy = a_ok & b_ok;
      OP_BGEZ, OP_BGTZ, OP_BLEZ, OP_BLTZ: rdy = a_ok;
      default:                           rdy = 1'b1;
    endcase
    return rdy;
  endfunction

  function automatic logic op_countable(input logic [2:0] op);
    return (op != OP_NONE) && (op != OP_RSVD);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition evaluation
//
// Ports:
//   cmp_op_i   comparison selector (bru_pkg encoding)
//   op_a_i     operand A, signed two's complement
//   op_b_i     operand B, signed two's complement
//   taken_o    branch condition holds
//   illegal_o  reserved cmp_op; the branch is reported not taken
module branch_cond_eval
  import bru_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        cmp_op_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic              taken_o,
  output logic              illegal_o
);

  logic a_neg;
  logic a_zero;

  assign a_neg  = op_a_i[DATA_W-1];
  assign a_zero = (op_a_i == '0);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (cmp_op_e'(cmp_op_i))
      OP_BGEZ: taken_o = ~a_neg;
      OP_BEQ:  taken_o = (op_a_i == op_b_i);
      OP_BNE:  taken_o = (op_a_i != op_b_i);
      OP_BGTZ: taken_o = ~a_neg & ~a_zero;
      OP_BLEZ: taken_o = a_neg | a_zero;
      OP_BLTZ: taken_o = a_neg;
      OP_RSVD: illegal_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch resolution with operand wait and result handshake
//
// Optional feature: define BRU_STATS_EN to add the taken_cnt/branch_cnt
// statistics counters and their ports.
//
// Ports:
//   Clk, Rst_n               clock, asynchronous active-low reset
//   in_valid / in_ready      request handshake
//   cmp_op, pc, offset       branch kind, branch PC, signed word offset
//   pred_taken               front-end prediction, compared for mispredict
//   op_a, op_b, a_ok, b_ok   forwarded operands and availability flags
//   flush                    drops any in-flight branch, blocks acceptance
//   out_valid / out_ready    result handshake
//   taken, target            resolved direction and branch target
//   redirect_pc              next fetch address (target or pc+4)
//   mispredict, illegal_op   taken ^ pred_taken, reserved cmp_op flag
//   taken_cnt, branch_cnt    statistics (BRU_STATS_EN only)
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          cmp_op,
  input  logic [ADDR_W-1:0]   pc,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                pred_taken,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  input  logic                a_ok,
  input  logic                b_ok,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                taken,
  output logic [ADDR_W-1:0]   target,
  output logic [ADDR_W-1:0]   redirect_pc,
  output logic                mispredict,
`ifdef BRU_STATS_EN
  output logic [CNT_W-1:0]    taken_cnt,
  output logic [CNT_W-1:0]    branch_cnt,
`endif
  output logic                illegal_op
);

  bru_state_e state_q, state_d;

  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [OFFSET_W-1:0] off_q;
  logic                pred_q;

  logic                taken_q, illegal_q, mispred_q, countable_q;
  logic [ADDR_W-1:0]   target_q, redirect_q;

  logic                accept;
  logic                eval;
  logic [2:0]          cur_op;
  logic [ADDR_W-1:0]   cur_pc;
  logic [OFFSET_W-1:0] cur_off;
  logic                cur_pred;
  logic                cur_ops_ok;
  logic                cond_taken, cond_illegal;
  logic [ADDR_W-1:0]   seq_pc, br_target;

  assign in_ready = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_RESULT) & out_ready));
  assign accept   = in_valid & in_ready;

  // A request accepted this cycle is evaluated from the live inputs; a
  // branch parked in WAIT_OPS uses its captured fields with live operands.
  assign cur_op   = accept ? cmp_op     : op_q;
  assign cur_pc   = accept ? pc         : pc_q;
  assign cur_off  = accept ? offset     : off_q;
  assign cur_pred = accept ? pred_taken : pred_q;

  assign cur_ops_ok = ops_ready(cur_op, a_ok, b_ok);

  branch_cond_eval #(
    .DATA_W (DATA_W)
  ) u_cond (
    .cmp_op_i  (cur_op),
    .op_a_i    (op_a),
    .op_b_i    (op_b),
    .taken_o   (cond_taken),
    .illegal_o (cond_illegal)
  );

  // Both sums wrap naturally at ADDR_W bits.
  assign seq_pc    = cur_pc + ADDR_W'(32'd4);
  assign br_target = seq_pc + (ADDR_W'($signed(cur_off)) << 2);

  always_comb begin
    state_d = state_q;
    eval    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = cur_ops_ok ? ST_RESULT : ST_WAIT_OPS;
          eval    = cur_ops_ok;
        end
      end
      ST_WAIT_OPS: begin
        if (cur_ops_ok) begin
          state_d = ST_RESULT;
          eval    = 1'b1;
        end
      end
      ST_RESULT: begin
        if (accept) begin
          state_d = cur_ops_ok ? ST_RESULT : ST_WAIT_OPS;
          eval    = cur_ops_ok;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      eval    = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_q   <= '0;
      pc_q   <= '0;
      off_q  <= '0;
      pred_q <= 1'b0;
    end else if (accept) begin
      op_q   <= cmp_op;
      pc_q   <= pc;
      off_q  <= offset;
      pred_q <= pred_taken;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      mispred_q   <= 1'b0;
      countable_q <= 1'b0;
      target_q    <= '0;
      redirect_q  <= '0;
    end else if (eval) begin
      taken_q     <= cond_taken;
      illegal_q   <= cond_illegal;
      mispred_q   <= cond_taken ^ cur_pred;
      countable_q <= op_countable(cur_op);
      target_q    <= br_target;
      redirect_q  <= cond_taken ? br_target : seq_pc;
    end
  end

  assign out_valid   = (state_q == ST_RESULT);
  assign taken       = taken_q;
  assign illegal_op  = illegal_q;
  assign mispredict  = mispred_q;
  assign target      = target_q;
  assign redirect_pc = redirect_q;

`ifdef BRU_STATS_EN
  logic out_hs;
  logic [CNT_W-1:0] taken_cnt_q, branch_cnt_q;

  // A flushed result never completes its handshake, so it is not counted.
  assign out_hs = (state_q == ST_RESULT) & out_ready & ~flush;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      taken_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else if (out_hs && countable_q) begin
      branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (taken_q) begin
        taken_cnt_q <= taken_cnt_q + CNT_W'(1);
      end
    end
  end

  assign taken_cnt  = taken_cnt_q;
  assign branch_cnt = branch_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  logic             unused_countable;
  assign unused_cnt_w     = '0;
  assign unused_countable = countable_q;
`endif

endmodule
